threefish_round_ctrl: RTL and testbench

Sequencing controller for the Threefish-512 encryption datapath. It accepts a block, then drives the datapath through 72 rounds. Each round is one MIX plus word-permutation step. A subkey injection precedes every group of 4 rounds, and one final injection follows the last round. It owns the round, phase and subkey counters and the input/output valid-ready handshakes. It generates only control strobes and indices; the 512-bit state register, MIX units, permutation and key schedule live in the datapath.

---
 rtl/threefish_round_ctrl_if.sv | 29 ++
 rtl/threefish_round_ctrl.sv | 118 +++++++++++
 tb/tb_threefish_round_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/threefish_round_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | threefish_round_ctrl_if : handshake and strobe bundle of the         |
// | Threefish-512 round controller.                    Revision: 1.0     |
// +----------------------------------------------------------------------+
interface threefish_round_ctrl_if;
   logic       abort;
   logic       in_valid;
   logic       in_ready;
   logic       load_en;
   logic       inj_en;
   logic [4:0] subkey_idx;
   logic       rnd_en;
   logic [2:0] rot_sel;
   logic       busy;
   logic       out_valid;
   logic       out_ready;

   // master is the controller side; slave is the source/datapath/consumer side.
   modport master (
      input  abort, in_valid, out_ready,
      output in_ready, load_en, inj_en, subkey_idx, rnd_en, rot_sel, busy, out_valid
   );
   modport slave (
      output abort, in_valid, out_ready,
      input  in_ready, load_en, inj_en, subkey_idx, rnd_en, rot_sel, busy, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/threefish_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | threefish_round_ctrl : sequences load, subkey injections and rounds  |
// | of the Threefish-512 datapath.                     Revision: 1.0     |
// +----------------------------------------------------------------------+
module threefish_round_ctrl #(
   parameter int NUM_ROUNDS = 72,
   parameter int INJ_PERIOD = 4
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   threefish_round_ctrl_if.master      ctrl_io
);
   localparam int NUM_SUBKEYS = NUM_ROUNDS / INJ_PERIOD + 1;
   localparam int RND_W       = 7;
   localparam int SK_W        = 5;
   localparam int PH_W        = (INJ_PERIOD > 1) ? $clog2(INJ_PERIOD) : 1;

   localparam logic [RND_W-1:0] c_RND_LAST = RND_W'(NUM_ROUNDS - 1);
   localparam logic [SK_W-1:0]  c_SK_LAST  = SK_W'(NUM_SUBKEYS - 1);
   localparam logic [PH_W-1:0]  c_PH_LAST  = PH_W'(INJ_PERIOD - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_INJECT = 2'd1;
   localparam logic [1:0] S_ROUND  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [RND_W-1:0] rnd_cnt_q, rnd_cnt_d;
   logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
   logic [SK_W-1:0]  sk_cnt_q, sk_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rnd_cnt_q <= '0;
         ph_cnt_q  <= '0;
         sk_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         rnd_cnt_q <= rnd_cnt_d;
         ph_cnt_q  <= ph_cnt_d;
         sk_cnt_q  <= sk_cnt_d;
      end
   end

   // Counters saturate at their last value so DONE still shows the final
   // subkey and rotation row; they are cleared whenever IDLE is re-entered.
   always_comb begin
      state_d   = state_q;
      rnd_cnt_d = rnd_cnt_q;
      ph_cnt_d  = ph_cnt_q;
      sk_cnt_d  = sk_cnt_q;
      if (ctrl_io.abort) begin
         state_d   = S_IDLE;
         rnd_cnt_d = '0;
         ph_cnt_d  = '0;
         sk_cnt_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ctrl_io.in_valid) begin
                  state_d   = S_INJECT;
                  rnd_cnt_d = '0;
                  ph_cnt_d  = '0;
                  sk_cnt_d  = '0;
               end
            end
            S_INJECT: begin
               if (sk_cnt_q == c_SK_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d  = S_ROUND;
                  ph_cnt_d = '0;
                  sk_cnt_d = sk_cnt_q + 1'b1;
               end
            end
            S_ROUND: begin
               if (rnd_cnt_q != c_RND_LAST) begin
                  rnd_cnt_d = rnd_cnt_q + 1'b1;
               end
               if (ph_cnt_q == c_PH_LAST) begin
                  state_d  = S_INJECT;
                  ph_cnt_d = '0;
               end else begin
                  ph_cnt_d = ph_cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               if (ctrl_io.out_ready) begin
                  state_d   = S_IDLE;
                  rnd_cnt_d = '0;
                  ph_cnt_d  = '0;
                  sk_cnt_d  = '0;
               end
            end
            default: begin
               state_d   = S_IDLE;
               rnd_cnt_d = '0;
               ph_cnt_d  = '0;
               sk_cnt_d  = '0;
            end
         endcase
      end
   end

   always_comb begin
      ctrl_io.in_ready   = (state_q == S_IDLE);
      ctrl_io.load_en    = (state_q == S_IDLE) && ctrl_io.in_valid && !ctrl_io.abort;
      ctrl_io.inj_en     = (state_q == S_INJECT);
      ctrl_io.rnd_en     = (state_q == S_ROUND);
      ctrl_io.out_valid  = (state_q == S_DONE);
      ctrl_io.busy       = (state_q != S_IDLE);
      ctrl_io.subkey_idx = sk_cnt_q;
      ctrl_io.rot_sel    = rnd_cnt_q[2:0];
   end
endmodule
`default_nettype wire

// File: tb/tb_threefish_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_threefish_round_ctrl : scoreboard bench for the round controller. |
// |                                                    Revision: 1.0     |
// +----------------------------------------------------------------------+
module tb_threefish_round_ctrl;
   logic clk;
   logic rst_n;
   threefish_round_ctrl_if bus_if ();

   threefish_round_ctrl #(.NUM_ROUNDS(72), .INJ_PERIOD(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctrl_io (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic       is_inj;
      logic [4:0] val;
   } sb_t;

   sb_t sb_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  n        = 0;
   int  rnd_seen = 0;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Expected strobe sequence of one block: inject k, then 4 rounds, ... inject 18.
   task automatic push_sched();
      for (int s = 0; s < 19; s++) begin
         sb_q.push_back('{1'b1, 5'(s)});
         if (s < 18)
            for (int r = 0; r < 4; r++) sb_q.push_back('{1'b0, 5'((s * 4 + r) % 8)});
      end
   endtask

   always @(negedge clk) begin
      sb_t e;
      if (rst_n && (bus_if.inj_en || bus_if.rnd_en)) begin
         check("excl_inj_rnd", int'(bus_if.inj_en & bus_if.rnd_en), 0);
         check("excl_ov_load", int'(bus_if.out_valid | bus_if.load_en), 0);
         if (bus_if.rnd_en) rnd_seen++;
         if (sb_q.size() == 0) begin
            check("sb_unexpected_strobe", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("sb_kind", int'(bus_if.inj_en), int'(e.is_inj));
            check("sb_idx", bus_if.inj_en ? int'(bus_if.subkey_idx) : int'(bus_if.rot_sel),
                  int'(e.val));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      n++;
   endtask

   // Called at a negedge in IDLE; returns at the negedge of cycle n=1.
   task automatic start_block(input bit keep_valid);
      bus_if.in_valid = 1'b1;
      #1;
      check("load_en_T0", int'(bus_if.load_en), 1);
      push_sched();
      rnd_seen = 0;
      @(posedge clk);
      @(negedge clk);
      n = 1;
      if (!keep_valid) bus_if.in_valid = 1'b0;
   endtask

   task automatic finish_block();
      int guard = 0;
      bus_if.out_ready = 1'b1;
      while (!bus_if.out_valid && guard < 200) begin
         step();
         guard++;
      end
      check("done_cycle", n, 92);
      check("sb_drained", sb_q.size(), 0);
      step();
      check("idle_after_done", int'(bus_if.in_ready), 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"}, int'(bus_if.in_ready), 1);
      check({tag, "_busy"}, int'(bus_if.busy), 0);
      check({tag, "_inj_en"}, int'(bus_if.inj_en), 0);
      check({tag, "_rnd_en"}, int'(bus_if.rnd_en), 0);
      check({tag, "_out_valid"}, int'(bus_if.out_valid), 0);
      check({tag, "_subkey_idx"}, int'(bus_if.subkey_idx), 0);
      check({tag, "_rot_sel"}, int'(bus_if.rot_sel), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int loads;
      int ov_bad;
      int guard;

      rst_n            = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.abort     = 1'b0;
      bus_if.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outputs("rst");
      bus_if.in_valid = 1'b1;
      #1;
      check("rst_load_follows_valid", int'(bus_if.load_en), 1);
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single block, consumer always ready
      bus_if.out_ready = 1'b1;
      start_block(1'b0);
      loads  = 0;
      ov_bad = 0;
      while (n < 92) begin
         if (bus_if.load_en) loads++;
         if (bus_if.out_valid) ov_bad++;
         step();
      end
      check("t1_out_valid_92", int'(bus_if.out_valid), 1);
      check("t1_subkey_done", int'(bus_if.subkey_idx), 18);
      check("t1_rot_done", int'(bus_if.rot_sel), 7);
      check("t1_round_count", rnd_seen, 72);
      check("t1_sb_drained", sb_q.size(), 0);
      check("t1_early_out_valid", ov_bad, 0);
      step();
      check("t1_in_ready_93", int'(bus_if.in_ready), 1);
      check("t1_out_valid_93", int'(bus_if.out_valid), 0);
      check("t1_extra_loads", loads, 0);

      // Output backpressure until cycle 120
      bus_if.out_ready = 1'b0;
      start_block(1'b0);
      ov_bad = 0;
      while (n < 92) begin
         if (bus_if.out_valid) ov_bad++;
         step();
      end
      check("t2_early_out_valid", ov_bad, 0);
      ov_bad = 0;
      while (n < 120) begin
         if (!bus_if.out_valid || bus_if.subkey_idx != 5'd18 || bus_if.in_ready || !bus_if.busy)
            ov_bad++;
         step();
      end
      check("t2_hold_bad_cycles", ov_bad, 0);
      check("t2_out_valid_120", int'(bus_if.out_valid), 1);
      bus_if.out_ready = 1'b1;
      step();
      check("t2_idle_121", int'(bus_if.in_ready), 1);
      check("t2_ov_low_121", int'(bus_if.out_valid), 0);

      // in_valid held high through a whole block
      start_block(1'b1);
      loads = 0;
      while (n < 92) begin
         if (bus_if.load_en) loads++;
         step();
      end
      check("t3_loads_while_busy", loads, 0);
      check("t3_out_valid_92", int'(bus_if.out_valid), 1);
      step();
      #1;
      check("t3_second_load_93", int'(bus_if.load_en), 1);
      push_sched();
      rnd_seen = 0;
      @(posedge clk);
      @(negedge clk);
      n = 1;
      bus_if.in_valid = 1'b0;
      finish_block();

      // Abort mid-round at cycle 40
      start_block(1'b0);
      ov_bad = 0;
      while (n < 40) begin
         if (bus_if.out_valid) ov_bad++;
         step();
      end
      check("t4_round_at_40", int'(bus_if.rnd_en), 1);
      bus_if.abort = 1'b1;
      step();
      bus_if.abort = 1'b0;
      check_idle_outputs("t4_abort");
      check("t4_sb_left", sb_q.size(), 51);
      check("t4_out_valid_seen", ov_bad, 0);
      sb_q.delete();
      step();
      start_block(1'b0);
      finish_block();

      // Abort colliding with out_ready in DONE
      bus_if.out_ready = 1'b0;
      start_block(1'b0);
      guard = 0;
      while (!bus_if.out_valid && guard < 200) begin
         step();
         guard++;
      end
      check("t5_done_cycle", n, 92);
      bus_if.abort     = 1'b1;
      bus_if.out_ready = 1'b1;
      step();
      bus_if.abort = 1'b0;
      check_idle_outputs("t5_done_abort");

      // Abort colliding with in_valid in IDLE
      bus_if.abort    = 1'b1;
      bus_if.in_valid = 1'b1;
      #1;
      check("t5_load_blocked", int'(bus_if.load_en), 0);
      step();
      bus_if.abort    = 1'b0;
      bus_if.in_valid = 1'b0;
      check("t5_not_accepted_busy", int'(bus_if.busy), 0);
      check("t5_not_accepted_ready", int'(bus_if.in_ready), 1);
      step();
      check("t5_no_inject", int'(bus_if.inj_en), 0);

      // Asynchronous reset in the inject cycle at n=56
      start_block(1'b0);
      while (n < 56) step();
      check("t6_inject_56", int'(bus_if.inj_en), 1);
      check("t6_subkey_56", int'(bus_if.subkey_idx), 11);
      #1;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("t6_async");
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_block(1'b0);
      finish_block();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
